// File: rtl/debounce_filter_bank.sv
// debounce_filter_bank: per-channel synchroniser, shared prescaler, hysteresis or majority filter with edge pulses
module debounce_filter_bank #(
    parameter int CHANNELS = 4,
    parameter int N        = 3,
    parameter int MODE     = 0,
    parameter int SYNC     = 2,
    parameter int DIV      = 1,
    parameter bit INIT     = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);
    localparam int CW = $clog2(N);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CHANNELS-1:0] INIT_V = {CHANNELS{INIT}};

    logic [CHANNELS-1:0] sync_q [SYNC];
    logic [CHANNELS-1:0] s, sig_out_q, sig_out_d, rise_q, fall_q;
    logic [PW-1:0] pre_q, pre_d;
    logic tick;

    assign s       = sync_q[SYNC-1];
    assign tick    = enable && pre_q == PW'(DIV - 1);
    assign pre_d   = !enable ? pre_q : tick ? '0 : pre_q + 1'b1;
    assign sig_out = sig_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC; k++) sync_q[k] <= INIT_V;
            pre_q     <= '0;
            sig_out_q <= INIT_V;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
            pre_q     <= pre_d;
            sig_out_q <= sig_out_d;
            rise_q    <= sig_out_d & ~sig_out_q;
            fall_q    <= ~sig_out_d & sig_out_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic out_d;
        assign sig_out_d[c] = out_d;
        if (MODE == 0) begin : g_hys
            logic [CW-1:0] cnt_q, cnt_d;
            // A disagreement run must reach N consecutive ticks before the output follows
            always_comb begin
                cnt_d = cnt_q;
                out_d = sig_out_q[c];
                if (tick) begin
                    if (s[c] == sig_out_q[c]) cnt_d = '0;
                    else if (cnt_q == CW'(N - 1)) begin
                        cnt_d = '0;
                        out_d = s[c];
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            always_ff @(posedge clock) begin
                if (reset) cnt_q <= '0;
                else cnt_q <= cnt_d;
            end
        end else begin : g_maj
            logic [N-1:0] win_q, win_d;
            always_comb begin
                win_d = tick ? {win_q[N-2:0], s[c]} : win_q;
                out_d = tick ? ($countones(win_d) > N / 2) : sig_out_q[c];
            end
            always_ff @(posedge clock) begin
                if (reset) win_q <= {N{INIT}};
                else win_q <= win_d;
            end
        end
    end
endmodule

// File: tb/tb_debounce_filter_bank.sv
// tb_debounce_filter_bank: directed checks of hysteresis, prescaler/enable and majority configurations
module tb_debounce_filter_bank;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst0, en0, rst1, en1, rst2, en2;
    logic [3:0] in0, in1, in2;
    logic [3:0] out0, ri0, fa0, out1, ri1, fa1, out2, ri2, fa2;
    int checks = 0;
    int failures = 0;

    debounce_filter_bank u0 (
        .clock(clock), .reset(rst0), .enable(en0), .sig_in(in0),
        .sig_out(out0), .rise(ri0), .fall(fa0)
    );
    debounce_filter_bank #(.DIV(4)) u1 (
        .clock(clock), .reset(rst1), .enable(en1), .sig_in(in1),
        .sig_out(out1), .rise(ri1), .fall(fa1)
    );
    debounce_filter_bank #(.MODE(1), .N(5)) u2 (
        .clock(clock), .reset(rst2), .enable(en2), .sig_in(in2),
        .sig_out(out2), .rise(ri2), .fall(fa2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int seq [7] = '{1, 1, 0, 1, 0, 0, 0};
    int eo  [7] = '{0, 0, 0, 1, 1, 0, 0};
    int er  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int ef  [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [3:0] acc;

    initial begin
        rst0 = 1; en0 = 1; in0 = 4'hF;
        rst1 = 1; en1 = 1; in1 = 4'h0;
        rst2 = 1; en2 = 1; in2 = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_out", out0, 4'h0);
            check("rst_pulse", {ri0, fa0}, 8'h00);
        end
        rst0 = 0;
        step(1);
        check("rel_out", out0, 4'h0);
        check("rel_pulse", {ri0, fa0}, 8'h00);
        step(3);
        check("rel_out4", out0, 4'h0);
        step(1);
        check("rel_out5", out0, 4'hF);
        check("rel_rise5", ri0, 4'hF);
        step(1);
        check("rel_rise6", ri0, 4'h0);

        in0 = 4'h0;
        step(5);
        check("all_fall", {out0, fa0}, 8'h0F);
        step(1);
        in0 = 4'h1;
        step(4);
        check("step_out4", out0, 4'h0);
        step(1);
        check("step_out5", out0, 4'h1);
        check("step_rise", {ri0, fa0}, 8'h10);
        step(1);
        check("step_rise_end", ri0, 4'h0);
        in0 = 4'h0;
        step(4);
        check("fall_out4", out0, 4'h1);
        step(1);
        check("fall_out5", {out0, fa0}, 8'h01);
        step(1);

        acc = 0;
        in0 = 4'h2;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) in0 = 4'h0;
            step(1);
            acc |= ri0 | out0;
        end
        check("glitch2", acc, 4'h0);
        in0 = 4'h2;
        step(3);
        in0 = 4'h0;
        step(2);
        check("glitch3", {out0, ri0}, 8'h22);
        step(10);
        check("glitch3_settle", out0, 4'h0);

        in0 = 4'hF;
        step(4);
        check("multi_out4", out0, 4'h0);
        step(1);
        check("multi_out5", {out0, ri0}, 8'hFF);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in0 = {~in0[3], 3'b111};
            step(1);
            acc |= fa0 | ~out0;
        end
        check("noise_ch3", {acc, out0}, 8'h0F);

        step(1);
        rst1 = 0;
        in1 = 4'h4;
        step(11);
        check("div_out11", out1, 4'h0);
        step(1);
        check("div_out12", {out1, ri1}, 8'h44);
        step(1);
        check("div_rise_end", ri1, 4'h0);
        in1 = 4'h0;
        step(4);
        en1 = 0;
        step(10);
        check("frozen", out1, 4'h4);
        en1 = 1;
        step(6);
        check("en_out_pre", {out1, fa1}, 8'h40);
        step(1);
        check("en_out_fall", {out1, fa1}, 8'h04);
        in1 = 4'h4;
        step(8);
        rst1 = 1;
        step(1);
        check("midrst", {out1, ri1}, 8'h00);
        rst1 = 0;
        step(11);
        check("midrst_out11", out1, 4'h0);
        step(1);
        check("midrst_out12", {out1, ri1}, 8'h44);

        rst2 = 0;
        for (int i = 0; i < 9; i++) begin
            in2 = (i < 7) ? 4'(seq[i]) : 4'h0;
            step(1);
            if (i >= 2) begin
                check("maj_out", out2, 4'(eo[i-2]));
                check("maj_pulse", {ri2, fa2}, {4'(er[i-2]), 4'(ef[i-2])});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
